// File: rtl/dibu_debug_pkg.sv
// -----------------------------------------------------------------------------
// dibu_debug_pkg
// Shared definitions for the debug read-out blocks.
//   dump_state_t : state encoding of the register-file dump engine
//   DUMP_HDR     : first byte of every dump frame
// -----------------------------------------------------------------------------
package dibu_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_FETCH   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SEND    = 3'd4,
    ST_CSUM    = 3'd5
  } dump_state_t;

  localparam logic [7:0] DUMP_HDR = 8'hA5;

endpackage : dibu_debug_pkg

// File: rtl/regfile_dumper.sv
// -----------------------------------------------------------------------------
// regfile_dumper
// Reads every register of the CPU register file through its registered debug
// read port and streams the contents as a framed byte stream:
//   0xA5, reg0 bytes (LSB first), reg1 bytes, ..., XOR checksum of data bytes.
//
// Ports
//   i_clk         : clock, all logic on posedge
//   i_rst         : synchronous active-high reset
//   i_start       : one-cycle dump request, honoured only when idle
//   o_busy        : high while a frame is in progress
//   o_rf_addr     : register file debug read address (0 when idle)
//   i_rf_data     : register file read data, valid one cycle after o_rf_addr
//   o_out_valid   : byte available
//   i_out_ready   : sink accepts byte
//   o_out_data    : byte value
//   o_out_last    : marks the checksum byte (end of frame)
//   o_dbg_state   : current FSM state, for debug and checkers
//
// Byte stream handshake: a byte moves on a posedge where o_out_valid and
// i_out_ready are both high. o_out_valid depends on state only, and while it
// is high without i_out_ready, o_out_data/o_out_last are held because the
// registers they come from only change on a handshake.
// -----------------------------------------------------------------------------
module regfile_dumper
  import dibu_debug_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int N_REGS = 8,
  parameter int ADDR_W = $clog2(N_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_rf_addr,
  input  logic [WIDTH-1:0]  i_rf_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [7:0]        o_out_data,
  output logic              o_out_last,
  output dump_state_t       o_dbg_state
);

  localparam int BYTES = WIDTH / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(N_REGS - 1);

  dump_state_t       r_state;
  logic [ADDR_W-1:0] r_index;
  logic [BC_W-1:0]   r_byte_cnt;
  logic [WIDTH-1:0]  r_buf;
  logic [7:0]        r_csum;

  dump_state_t       w_state_nxt;
  logic [ADDR_W-1:0] w_index_nxt;
  logic [BC_W-1:0]   w_byte_cnt_nxt;
  logic [WIDTH-1:0]  w_buf_nxt;
  logic [7:0]        w_csum_nxt;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_index    <= '0;
      r_byte_cnt <= '0;
      r_buf      <= '0;
      r_csum     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_index    <= w_index_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_buf      <= w_buf_nxt;
      r_csum     <= w_csum_nxt;
    end
  end

  // Next-state, datapath updates and stream outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_index_nxt    = r_index;
    w_byte_cnt_nxt = r_byte_cnt;
    w_buf_nxt      = r_buf;
    w_csum_nxt     = r_csum;
    o_out_valid    = 1'b0;
    o_out_data     = 8'h00;
    o_out_last     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt    = ST_HDR;
          w_index_nxt    = '0;
          w_byte_cnt_nxt = '0;
          w_csum_nxt     = 8'h00;
        end
      end

      ST_HDR: begin
        o_out_valid = 1'b1;
        o_out_data  = DUMP_HDR;
        if (i_out_ready) begin
          w_state_nxt = ST_FETCH;
        end
      end

      // Address is already on o_rf_addr; the register file answers next cycle.
      ST_FETCH: begin
        w_state_nxt = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        w_buf_nxt   = i_rf_data;
        w_state_nxt = ST_SEND;
      end

      ST_SEND: begin
        o_out_valid = 1'b1;
        o_out_data  = r_buf[7:0];
        if (i_out_ready) begin
          w_csum_nxt = r_csum ^ r_buf[7:0];
          if (r_byte_cnt != LAST_BYTE) begin
            w_buf_nxt      = r_buf >> 8;
            w_byte_cnt_nxt = r_byte_cnt + 1'b1;
          end else begin
            w_byte_cnt_nxt = '0;
            // Explicit compare so the index never wraps past the last register.
            if (r_index == LAST_REG) begin
              w_state_nxt = ST_CSUM;
            end else begin
              w_index_nxt = r_index + 1'b1;
              w_state_nxt = ST_FETCH;
            end
          end
        end
      end

      ST_CSUM: begin
        o_out_valid = 1'b1;
        o_out_data  = r_csum;
        o_out_last  = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
          w_index_nxt = '0;  // keeps o_rf_addr at 0 while idle
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_rf_addr   = r_index;
  assign o_dbg_state = r_state;

endmodule : regfile_dumper

// File: doc/regfile_dumper.md
# regfile_dumper

Debug read-out engine for the CPU register file. On a `start` pulse it reads every register in order through a registered read port and streams the contents out as a framed byte stream over a valid/ready interface: header, data bytes, XOR checksum. It is the reader counterpart of the write-enabled registers. It sits between the register file's debug read port and the host link (UART TX or similar).

## Interface
- `width`, 8: register width in bits; must be a multiple of 8 (8, 16, 32).
- `n_regs`, 8: number of registers dumped; power of two, 2..256.
- `addr_w`, $clog2(n_regs): register address width (derived).

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a dump.
- `busy`  out  1  high from the cycle after accepted `start` until the final handshake.
- `rf_addr`  out  addr_w  register file debug read address.
- `rf_data`  in  width  register file read data, valid one cycle after `rf_addr`.
- `out_valid`  out  1  byte available.
- `out_ready`  in  1  sink accepts byte.
- `out_data`  out  8  byte value.
- `out_last`  out  1  marks the checksum byte, the final byte of the frame.

## Operation
- Frame: 0xA5, then for reg 0..n_regs-1 the `width/8` bytes of each register, least-significant byte first, then the checksum.
- Checksum is the XOR of all data bytes. The header is excluded.
- States and transitions:
  - IDLE: `busy`=0, `out_valid`=0. `start`=1 → HDR; clear index, byte counter and checksum.
  - HDR: `out_valid`=1, `out_data`=0xA5. On handshake → FETCH.
  - FETCH: `rf_addr`=index, no output. → CAPTURE.
  - CAPTURE: latch `rf_data` into the shift buffer. → SEND.
  - SEND: `out_data` = buffer[7:0]. On handshake:
    - XOR the byte into the checksum.
    - If not the last byte of the register: shift the buffer right by 8 and increment the byte counter.
    - Else if index = n_regs-1 → CSUM.
    - Else increment the index → FETCH.
  - CSUM: `out_data`=checksum, `out_last`=1. On handshake → IDLE.
- `start` is ignored while not in IDLE.
- `rf_addr` always drives the current index; it is 0 in IDLE.

## Timing
- Reset values: state IDLE, `busy`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `rf_addr`=0, checksum 0.
- `rst` mid-frame aborts on the next edge with no further bytes; the next `start` begins a fresh frame with the header.
- Handshake: a byte is transferred on a posedge with `out_valid`=1 and `out_ready`=1.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable. `out_valid` never drops without a handshake.
- `out_valid` is driven only from state. There is no combinational path from `out_ready` to `out_valid`.
- `out_ready` may be high before `out_valid`.
- Latency with `out_ready` tied high:
  - `start` at cycle 0 → header valid at cycle 1.
  - Each register costs 2 + width/8 cycles.
  - Frame length is 2 + n_regs·(2 + width/8) cycles until return to IDLE.
- Index wraps never occur: the last-register compare is explicit, and the counter width is addr_w.
- `start` asserted on the same edge as the CSUM handshake is ignored, since the state is not IDLE.

## Structure
- Shared package `dibu_debug_pkg`:
  - state enum `dump_state_t`
  - constant `DUMP_HDR` = 8'hA5
- Single module; no sub-module needed. The byte serializer is a shift register inside SEND.

## Test plan
- Reset + idle: `rst` 2 cycles, no `start` → `busy`=0, `out_valid`=0, `rf_addr`=0 for 20 cycles.
- Basic dump (width=8, n_regs=4, regs 0x11,0x22,0x33,0x44, `out_ready`=1) → bytes A5,11,22,33,44,44 (XOR); `out_last` only on the final byte; `busy` falls after it.
- Wide regs (width=16, n_regs=2, regs 0x1234, 0xABCD) → A5,34,12,CD,AB, checksum 0x34^0x12^0xCD^0xAB=0x40.
- Backpressure: random `out_ready` (30% high) during the basic dump → identical byte sequence; `out_data` stable during every stall cycle.
- Start while busy: pulse `start` mid-frame and on the CSUM handshake cycle → exactly one frame emitted, no extra header.
- Reset mid-frame: assert `rst` after the 3rd data byte → `out_valid`=0 next cycle. A new `start` → frame begins with A5 and a correct checksum (not polluted by the aborted bytes).
